// File: rtl/gcm_aes_seq_ctrl.sv
// gcm_aes_seq_ctrl: job-level sequencer feeding AAD then plaintext into gcm_aes.
// Optional macro GCM_SEQ_LAST_MASK_EN zeroes bits past the length in final blocks.
module gcm_aes_seq_ctrl #(
    parameter int PIPE_LAT    = 9,
    parameter int TAG_TIMEOUT = 64,
    parameter int LEN_W       = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [127:0]     job_key,
    input  logic [95:0]      job_iv,
    input  logic [LEN_W-1:0] job_aad_bits,
    input  logic [LEN_W-1:0] job_pt_bits,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [127:0]     s_data,
    output logic             core_new_instance,
    output logic             core_pt_instance,
    output logic [127:0]     core_key,
    output logic [95:0]      core_iv,
    output logic [127:0]     core_data,
    output logic [LEN_W-1:0] core_aad_size,
    output logic [LEN_W-1:0] core_pt_size,
    input  logic [127:0]     core_ct,
    input  logic [127:0]     core_tag,
    input  logic             core_tag_ready,
    output logic             m_ct_valid,
    output logic [127:0]     m_ct,
    output logic             done,
    output logic [127:0]     tag,
    output logic             err
);
    localparam int CW = LEN_W - 7;
    localparam int TW = $clog2(TAG_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AAD,
        S_PT,
        S_EMPTY,
        S_DRAIN
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]       aad_cnt;
    logic [CW-1:0]       pt_cnt;
    logic [CW-1:0]       job_aad_blk;
    logic [CW-1:0]       job_pt_blk;
    logic                first;
    logic [PIPE_LAT-1:0] lat_sr;
    logic [TW-1:0]       tcnt;
    logic                accept;
    logic                aad_issue;
    logic                pt_issue;
    logic                any_issue;
    logic                set_err;
    logic                tag_hit;
    logic [127:0]        aad_mask;
    logic [127:0]        pt_mask;
    logic [127:0]        ct_mask;

    assign job_aad_blk = job_aad_bits[LEN_W-1:7] + CW'(|job_aad_bits[6:0]);
    assign job_pt_blk  = job_pt_bits[LEN_W-1:7] + CW'(|job_pt_bits[6:0]);

    // Gate with rst so every output reads 0 while reset is held.
    assign job_ready = (state == S_IDLE) && !rst;
    assign accept    = job_valid && job_ready;

`ifdef GCM_SEQ_LAST_MASK_EN
    logic [6:0]          aad_rem;
    logic [6:0]          pt_rem;
    logic [PIPE_LAT-1:0] last_sr;

    function automatic logic [127:0] tail_mask(input logic [6:0] rem);
        logic [127:0] ones;
        ones = '1;
        return (rem == 7'd0) ? ones : ~(ones >> rem);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aad_rem <= '0;
            pt_rem  <= '0;
            last_sr <= '0;
        end else begin
            if (accept) begin
                aad_rem <= job_aad_bits[6:0];
                pt_rem  <= job_pt_bits[6:0];
            end
            last_sr <= {last_sr[PIPE_LAT-2:0],
                        pt_issue && (pt_cnt == CW'(1))};
        end
    end

    assign aad_mask = (aad_cnt == CW'(1)) ? tail_mask(aad_rem) : '1;
    assign pt_mask  = (pt_cnt == CW'(1)) ? tail_mask(pt_rem) : '1;
    assign ct_mask  = last_sr[PIPE_LAT-1] ? tail_mask(pt_rem) : '1;
`else
    assign aad_mask = '1;
    assign pt_mask  = '1;
    assign ct_mask  = '1;
`endif

    always_comb begin
        state_nxt         = state;
        s_ready           = 1'b0;
        aad_issue         = 1'b0;
        pt_issue          = 1'b0;
        any_issue         = 1'b0;
        set_err           = 1'b0;
        tag_hit           = 1'b0;
        core_new_instance = 1'b0;
        core_pt_instance  = 1'b0;
        core_data         = '0;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    if (job_aad_blk != '0)
                        state_nxt = S_AAD;
                    else if (job_pt_blk != '0)
                        state_nxt = S_PT;
                    else
                        state_nxt = S_EMPTY;
                end
            end
            S_AAD: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    aad_issue         = 1'b1;
                    any_issue         = 1'b1;
                    core_new_instance = first;
                    core_data         = s_data & aad_mask;
                    if (aad_cnt == CW'(1))
                        state_nxt = (pt_cnt != '0) ? S_PT : S_DRAIN;
                end else begin
                    set_err   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_PT: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    pt_issue          = 1'b1;
                    any_issue         = 1'b1;
                    core_new_instance = first;
                    core_pt_instance  = 1'b1;
                    core_data         = s_data & pt_mask;
                    if (pt_cnt == CW'(1))
                        state_nxt = S_DRAIN;
                end else begin
                    set_err   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_EMPTY: begin
                any_issue         = 1'b1;
                core_new_instance = 1'b1;
                state_nxt         = S_DRAIN;
            end
            S_DRAIN: begin
                if (core_tag_ready) begin
                    tag_hit   = 1'b1;
                    state_nxt = S_IDLE;
                end else if (tcnt == TW'(TAG_TIMEOUT - 1)) begin
                    set_err   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            aad_cnt       <= '0;
            pt_cnt        <= '0;
            first         <= 1'b0;
            lat_sr        <= '0;
            tcnt          <= '0;
            core_key      <= '0;
            core_iv       <= '0;
            core_aad_size <= '0;
            core_pt_size  <= '0;
            done          <= 1'b0;
            tag           <= '0;
            err           <= 1'b0;
        end else begin
            state  <= state_nxt;
            lat_sr <= {lat_sr[PIPE_LAT-2:0], pt_issue};
            done   <= tag_hit;
            if (tag_hit)
                tag <= core_tag;
            if (state == S_DRAIN)
                tcnt <= tcnt + TW'(1);
            else
                tcnt <= '0;
            if (accept) begin
                core_key      <= job_key;
                core_iv       <= job_iv;
                core_aad_size <= job_aad_bits;
                core_pt_size  <= job_pt_bits;
                aad_cnt       <= job_aad_blk;
                pt_cnt        <= job_pt_blk;
                first         <= 1'b1;
                err           <= 1'b0;
            end else begin
                if (set_err)
                    err <= 1'b1;
                if (any_issue)
                    first <= 1'b0;
                if (aad_issue)
                    aad_cnt <= aad_cnt - CW'(1);
                if (pt_issue)
                    pt_cnt <= pt_cnt - CW'(1);
            end
        end
    end

    assign m_ct_valid = lat_sr[PIPE_LAT-1];
    assign m_ct       = m_ct_valid ? (core_ct & ct_mask) : '0;

endmodule
